multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 61 ++++++
 rtl/multicycle_control_alu_op_decode.sv | 37 +++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller and datapath: FSM state codes,
// ALU operation selects, opcode/funct constants and memory read modes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLL  = 3'd2;
    localparam logic [2:0] ALU_SRL  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_OR   = 3'd5;
    localparam logic [2:0] ALU_SLT  = 3'd6;
    localparam logic [2:0] ALU_SLTU = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [1:0] MR_NONE  = 2'd0;
    localparam logic [1:0] MR_WORD  = 2'd1;
    localparam logic [1:0] MR_HALF  = 2'd2;
    localparam logic [1:0] MR_HALFU = 2'd3;

    function automatic logic [1:0] mem_read_mode(input logic [5:0] op);
        case (op)
            OP_LH:   return MR_HALF;
            OP_LHU:  return MR_HALFU;
            default: return MR_WORD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// Maps opcode/funct to an ALU operation; illegal flags an unknown opcode or an
// unknown funct on an R-type instruction.
module alu_op_decode
    import multicycle_control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] alu_sel,
    output logic       illegal
);

    always_comb begin
        alu_sel = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   alu_sel = ALU_ADD;
                    F_SUB:   alu_sel = ALU_SUB;
                    F_SLL:   alu_sel = ALU_SLL;
                    F_SRL:   alu_sel = ALU_SRL;
                    F_AND:   alu_sel = ALU_AND;
                    F_OR:    alu_sel = ALU_OR;
                    F_SLT:   alu_sel = ALU_SLT;
                    F_SLTU:  alu_sel = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ANDI: alu_sel = ALU_AND;
            OP_ORI:  alu_sel = ALU_OR;
            OP_BEQ:  alu_sel = ALU_SUB;
            OP_ADDI, OP_LW, OP_SW, OP_LH, OP_LHU: alu_sel = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM with bounded memory waits, a sticky TRAP
// state and a retired-instruction counter.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        i_or_d,
    output logic [1:0]  mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        pc_source,
    output logic        alu_src_a,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_sel,
    output logic [3:0]  state,
    output logic        trap,
    output logic [31:0] retired
);

    localparam int WCW = $clog2(MEM_WAIT_MAX + 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt;
    logic [2:0]     dec_sel;
    logic           dec_illegal;
    logic           timeout;
    logic           retire;
    logic           unused_zero;

    // zero gates the PC load in the datapath, not here
    assign unused_zero = zero;
    assign state       = state_q;
    // this cycle would be the MEM_WAIT_MAX-th cycle without mem_ready
    assign timeout     = !mem_ready && (wait_cnt == WCW'(MEM_WAIT_MAX - 1));

    alu_op_decode u_dec (
        .opcode  (opcode),
        .funct   (funct),
        .alu_sel (dec_sel),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d       = state_q;
        mem_req       = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = MR_NONE;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_b     = 2'd0;
        alu_sel       = ALU_ADD;
        trap          = 1'b0;
        retire        = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                mem_read  = MR_WORD;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_RTYPE:                     state_d = S_R_EXEC;
                    OP_LW, OP_SW, OP_LH, OP_LHU:  state_d = S_MEM_ADDR;
                    OP_BEQ:                       state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:     state_d = S_I_EXEC;
                    default:                      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                i_or_d   = 1'b1;
                mem_read = mem_read_mode(opcode);
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req   = 1'b1;
                i_or_d    = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_R_EXEC: begin
                alu_sel = dec_sel;
                state_d = dec_illegal ? S_TRAP : S_R_WB;
            end
            S_R_WB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_src_b = 2'd2;
                alu_sel   = dec_sel;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_sel       = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state_q <= state_d;
            // any state change clears the count, so each memory state starts fresh
            if (state_d != state_q)
                wait_cnt <= '0;
            else if (mem_req && !mem_ready)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                retired <= retired + 32'd1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a random
// instruction stream checked against a per-instruction cycle/strobe model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [5:0]  opcode, funct;
    logic        mem_req, i_or_d, mem_write, ir_write, pc_write, pc_write_cond;
    logic        pc_source, alu_src_a, reg_dst, mem_to_reg, reg_write, trap;
    logic [1:0]  mem_read, alu_src_b;
    logic [2:0]  alu_sel;
    logic [3:0]  state;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_SW = 3, K_BR = 4;

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .state(state), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    function automatic logic any_we();
        return ir_write | pc_write | pc_write_cond | reg_write | mem_write;
    endfunction

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = 6'd0; funct = 6'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (state !== S_FETCH) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_FETCH); end
        checks++; if (retired !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d exp=0", retired); end
        checks++; if (trap !== 1'b0) begin failures++; $display("FAIL reset_trap got=%0b exp=0", trap); end
        checks++; if ({mem_req, i_or_d, mem_read, alu_src_a, alu_src_b, alu_sel} !== {1'b1, 1'b0, 2'd1, 1'b0, 2'd1, 3'd0}) begin
            failures++; $display("FAIL reset_fetch_outputs got=%b", {mem_req, i_or_d, mem_read, alu_src_a, alu_src_b, alu_sel});
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        state_t exp_st[4];
        exp_st = '{S_FETCH, S_DECODE, S_R_EXEC, S_R_WB};
        do_reset();
        opcode = 6'b000000; funct = 6'b100000;
        for (int c = 0; c < 4; c++) begin
            mem_ready = 1'b1; #1;
            checks++; if (state !== exp_st[c]) begin failures++; $display("FAIL add_state c=%0d got=%0d exp=%0d", c, state, exp_st[c]); end
            checks++; if (reg_write !== (c == 3)) begin failures++; $display("FAIL add_reg_write c=%0d got=%0b", c, reg_write); end
            @(negedge clk);
        end
        checks++; if (retired !== 32'd1) begin failures++; $display("FAIL add_retired got=%0d exp=1", retired); end
    endtask

    task automatic test_lh();
        int n2 = 0;
        do_reset();
        opcode = 6'b100001;
        for (int c = 0; c < 7; c++) begin
            mem_ready = !(c == 3 || c == 4); #1;
            if (mem_read === 2'd2) n2++;
            if (c == 6) begin
                checks++; if (state !== S_MEM_WB || reg_write !== 1'b1 || mem_to_reg !== 1'b1) begin
                    failures++; $display("FAIL lh_wb state=%0d rw=%0b m2r=%0b", state, reg_write, mem_to_reg);
                end
            end
            @(negedge clk);
        end
        checks++; if (n2 !== 3) begin failures++; $display("FAIL lh_mem_read_cycles got=%0d exp=3", n2); end
        checks++; if (retired !== 32'd1 || state !== S_FETCH) begin failures++; $display("FAIL lh_done retired=%0d state=%0d", retired, state); end
    endtask

    task automatic test_beq();
        do_reset();
        opcode = 6'b000100;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b1; zero = 1'($urandom); #1;
            if (c == 2) begin
                checks++; if (pc_write_cond !== 1'b1 || alu_sel !== 3'd1 || pc_source !== 1'b1) begin
                    failures++; $display("FAIL beq_branch pwc=%0b alu=%0d psrc=%0b", pc_write_cond, alu_sel, pc_source);
                end
            end
            @(negedge clk);
        end
        checks++; if (retired !== 32'd1 || state !== S_FETCH) begin failures++; $display("FAIL beq_done retired=%0d state=%0d", retired, state); end
    endtask

    task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn, input int pre);
        int bad = 0;
        do_reset();
        opcode = op; funct = fn;
        for (int c = 0; c < pre + 6; c++) begin
            mem_ready = (c == 0) ? 1'b1 : 1'($urandom); #1;
            if (c >= pre && (state !== S_TRAP || trap !== 1'b1 || any_we() !== 1'b0 || mem_req !== 1'b0)) bad++;
            @(negedge clk);
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL illegal_trap op=%b fn=%b bad_cycles=%0d exp=0", op, fn, bad); end
        do_reset();
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH || trap !== 1'b0) begin failures++; $display("FAIL trap_reset state=%0d trap=%0b", state, trap); end
        @(negedge clk);
    endtask

    task automatic test_fetch_timeout();
        int n = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            mem_ready = 1'b0; #1;
            if (state !== S_FETCH) break;
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 15) begin failures++; $display("FAIL fetch_timeout_cycles got=%0d exp=15", n); end
        checks++; if (state !== S_TRAP || trap !== 1'b1) begin failures++; $display("FAIL fetch_timeout_trap state=%0d trap=%0b", state, trap); end
        @(negedge clk);
    endtask

    task automatic test_ready_at_limit();
        do_reset();
        opcode = 6'b001000;
        for (int c = 0; c < 15; c++) begin
            mem_ready = (c == 14); #1;
            if (c == 14) begin
                checks++; if (ir_write !== 1'b1) begin failures++; $display("FAIL limit_ir_write got=%0b exp=1", ir_write); end
            end
            @(negedge clk);
        end
        #1;
        checks++; if (state !== S_DECODE || trap !== 1'b0) begin failures++; $display("FAIL limit_ready_wins state=%0d trap=%0b", state, trap); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_mem_wr();
        do_reset();
        opcode = 6'b001101;
        for (int c = 0; c < 4; c++) begin mem_ready = 1'b1; @(negedge clk); end
        opcode = 6'b101011;
        for (int c = 0; c < 3; c++) begin mem_ready = 1'b1; @(negedge clk); end
        mem_ready = 1'b0; #1;
        checks++; if (state !== S_MEM_WR || mem_write !== 1'b1 || retired !== 32'd1) begin
            failures++; $display("FAIL sw_pre_reset state=%0d mw=%0b retired=%0d", state, mem_write, retired);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0; #1;
        checks++; if (state !== S_FETCH || mem_write !== 1'b0 || retired !== 32'd0) begin
            failures++; $display("FAIL sw_reset state=%0d mw=%0b retired=%0d", state, mem_write, retired);
        end
        checks++; if (any_we() !== 1'b0) begin failures++; $display("FAIL sw_reset_we got=1 exp=0"); end
        @(negedge clk);
    endtask

    task automatic get_op(input int i, output logic [5:0] op, output logic [5:0] fn,
                          output int kind, output logic [2:0] alu, output logic [1:0] mode);
        fn = 6'd0; alu = 3'd0; mode = 2'd0;
        case (i)
            0:  begin op = 6'b000000; fn = 6'b100000; kind = K_R; alu = 3'd0; end
            1:  begin op = 6'b000000; fn = 6'b100010; kind = K_R; alu = 3'd1; end
            2:  begin op = 6'b000000; fn = 6'b000000; kind = K_R; alu = 3'd2; end
            3:  begin op = 6'b000000; fn = 6'b000010; kind = K_R; alu = 3'd3; end
            4:  begin op = 6'b000000; fn = 6'b100100; kind = K_R; alu = 3'd4; end
            5:  begin op = 6'b000000; fn = 6'b100101; kind = K_R; alu = 3'd5; end
            6:  begin op = 6'b000000; fn = 6'b101010; kind = K_R; alu = 3'd6; end
            7:  begin op = 6'b000000; fn = 6'b101011; kind = K_R; alu = 3'd7; end
            8:  begin op = 6'b001000; kind = K_I; alu = 3'd0; end
            9:  begin op = 6'b001100; kind = K_I; alu = 3'd4; end
            10: begin op = 6'b001101; kind = K_I; alu = 3'd5; end
            11: begin op = 6'b100011; kind = K_LD; mode = 2'd1; end
            12: begin op = 6'b100001; kind = K_LD; mode = 2'd2; end
            13: begin op = 6'b100101; kind = K_LD; mode = 2'd3; end
            14: begin op = 6'b101011; kind = K_SW; end
            default: begin op = 6'b000100; kind = K_BR; end
        endcase
    endtask

    task automatic test_random();
        logic [5:0] op, fn;
        logic [2:0] alu, alu_obs;
        logic [1:0] mode;
        int kind, wf, wd, wl, c, rw, mw, pwc, irw, mr_bad, exp_cyc;
        logic [31:0] ret0;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            get_op(int'($urandom_range(0, 15)), op, fn, kind, alu, mode);
            if (kind == K_R && $urandom_range(0, 7) == 0) fn = (fn == 6'b100000) ? 6'b100000 : fn;
            wf = int'($urandom_range(0, 12));
            wd = int'($urandom_range(0, 12));
            opcode = op; funct = fn;
            exp_cyc = ((kind == K_LD) ? 5 : (kind == K_BR) ? 3 : 4) + wf
                      + ((kind == K_LD || kind == K_SW) ? wd : 0);
            wl = wf; c = 0; rw = 0; mw = 0; pwc = 0; irw = 0; mr_bad = 0; alu_obs = 3'd0;
            ret0 = retired;
            while (retired == ret0 && c < 80) begin
                zero = 1'($urandom);
                if (mem_req === 1'b1) begin
                    mem_ready = (wl == 0);
                    wl = (wl == 0) ? wd : wl - 1;
                end else begin
                    mem_ready = 1'($urandom);
                end
                #1;
                rw += int'(reg_write); mw += int'(mem_write);
                pwc += int'(pc_write_cond); irw += int'(ir_write);
                if (mem_req === 1'b1 && i_or_d === 1'b1 && mem_read !== mode) mr_bad++;
                if (c == wf + 2) alu_obs = alu_sel;
                c++;
                @(negedge clk);
            end
            checks++; if (c !== exp_cyc) begin failures++; $display("FAIL rand_cycles n=%0d op=%b got=%0d exp=%0d", n, op, c, exp_cyc); end
            checks++; if (retired !== ret0 + 32'd1) begin failures++; $display("FAIL rand_retired n=%0d got=%0d exp=%0d", n, retired, ret0 + 32'd1); end
            checks++; if (rw !== ((kind == K_SW || kind == K_BR) ? 0 : 1) || irw !== 1) begin
                failures++; $display("FAIL rand_writes n=%0d op=%b reg_write=%0d ir_write=%0d", n, op, rw, irw);
            end
            checks++; if (mw !== ((kind == K_SW) ? wd + 1 : 0) || pwc !== ((kind == K_BR) ? 1 : 0)) begin
                failures++; $display("FAIL rand_mem_branch n=%0d op=%b mem_write=%0d pwc=%0d", n, op, mw, pwc);
            end
            checks++; if (mr_bad !== 0) begin failures++; $display("FAIL rand_mem_read n=%0d op=%b bad=%0d exp=0", n, op, mr_bad); end
            if (kind == K_R || kind == K_I) begin
                checks++; if (alu_obs !== alu) begin failures++; $display("FAIL rand_alu_sel n=%0d op=%b fn=%b got=%0d exp=%0d", n, op, fn, alu_obs, alu); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_lh();
        test_beq();
        test_illegal(6'b111111, 6'd0, 2);
        test_illegal(6'b000000, 6'b111111, 3);
        test_fetch_timeout();
        test_ready_at_limit();
        test_reset_in_mem_wr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
